// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the fetch stage: FSM state encoding and the default
// widths / reset vector used by the fetch top level and its bus interface.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam int          DEF_DATAWIDTH    = 16;
    localparam int          DEF_ADDRWIDTH    = 16;
    localparam logic [15:0] DEF_RESET_VECTOR = 16'h0000;
    localparam int          DEF_MAX_WAIT     = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
// Bus bundle around the fetch stage: the req/ack read port towards instruction
// memory and the valid/ready port towards decode.
//   master : fetch stage (drives mem_req/mem_addr and instr/instr_pc/instr_valid)
//   slave  : environment (memory returns mem_ack/mem_rdata, decode drives
//            instr_ready)
// -----------------------------------------------------------------------------
interface instruction_fetch_if
    import instruction_fetch_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int ADDRWIDTH = DEF_ADDRWIDTH
);
    logic                 mem_req;
    logic [ADDRWIDTH-1:0] mem_addr;
    logic                 mem_ack;
    logic [DATAWIDTH-1:0] mem_rdata;
    logic [DATAWIDTH-1:0] instr;
    logic [ADDRWIDTH-1:0] instr_pc;
    logic                 instr_valid;
    logic                 instr_ready;

    modport master (
        output mem_req, mem_addr, instr, instr_pc, instr_valid,
        input  mem_ack, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_pc, instr_valid,
        output mem_ack, mem_rdata, instr_ready
    );
endinterface

// File: rtl/instruction_fetch_register.sv
// -----------------------------------------------------------------------------
// instruction_fetch_register
// Plain loadable register used as the instruction register of the fetch stage.
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset, clears the stored word
//   i_load : capture strobe
//   i_d    : data to capture
//   o_q    : stored word
// -----------------------------------------------------------------------------
module instruction_fetch_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: holds the PC, reads instruction memory over a req/ack handshake,
// captures the returned word and offers it to decode over valid/ready. A
// watchdog withdraws a request that stays unacknowledged for MAX_WAIT cycles,
// pulses fetch_error for one cycle and re-requests the same address.
//   clk           : rising-edge clock
//   reset         : asynchronous active-low reset
//   branch_taken  : redirect request, has priority over everything else
//   branch_target : new PC when branch_taken is high
//   fetch_error   : one-cycle pulse on watchdog expiry
//   bus (master)  : mem_req/mem_addr/mem_ack/mem_rdata and
//                   instr/instr_pc/instr_valid/instr_ready
// -----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                   DATAWIDTH    = DEF_DATAWIDTH,
    parameter int                   ADDRWIDTH    = DEF_ADDRWIDTH,
    parameter logic [ADDRWIDTH-1:0] RESET_VECTOR = ADDRWIDTH'(DEF_RESET_VECTOR),
    parameter int                   MAX_WAIT     = DEF_MAX_WAIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 branch_taken,
    input  logic [ADDRWIDTH-1:0] branch_target,
    output logic                 fetch_error,
    instruction_fetch_if.master  bus
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    fetch_state_t         r_state;
    logic [ADDRWIDTH-1:0] r_pc;
    logic                 r_mem_req;
    logic [ADDRWIDTH-1:0] r_mem_addr;
    logic [ADDRWIDTH-1:0] r_instr_pc;
    logic                 r_instr_valid;
    logic                 r_fetch_error;
    logic [WAIT_W-1:0]    r_wait_cnt;

    logic [ADDRWIDTH-1:0] w_pc_sel;
    logic                 w_capture;
    logic                 w_expire;
    logic [DATAWIDTH-1:0] w_instr;

    // PC to use for the next request: a branch overrides the sequential PC.
    assign w_pc_sel = branch_taken ? branch_target : r_pc;

    // Data is only taken while the request is actually on the bus; a branch
    // in the same cycle discards the returned word.
    assign w_capture = (r_state == ST_REQ) && r_mem_req && bus.mem_ack && !branch_taken;

    // Last unacknowledged cycle before the watchdog fires; an ack here wins.
    assign w_expire = (r_wait_cnt == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_VECTOR;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= RESET_VECTOR;
            r_instr_pc    <= RESET_VECTOR;
            r_instr_valid <= 1'b0;
            r_fetch_error <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            r_fetch_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_pc       <= w_pc_sel;
                    r_mem_addr <= w_pc_sel;
                    r_mem_req  <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= ST_REQ;
                end
                ST_REQ: begin
                    if (branch_taken) begin
                        r_pc       <= branch_target;
                        r_mem_addr <= branch_target;
                        r_mem_req  <= 1'b1;
                        r_wait_cnt <= '0;
                    end else if (!r_mem_req) begin
                        // Cycle after a watchdog expiry: re-issue the same address.
                        r_mem_req  <= 1'b1;
                        r_wait_cnt <= '0;
                    end else if (bus.mem_ack) begin
                        r_instr_pc    <= r_pc;
                        r_pc          <= r_pc + ADDRWIDTH'(1);
                        r_mem_req     <= 1'b0;
                        r_instr_valid <= 1'b1;
                        r_wait_cnt    <= '0;
                        r_state       <= ST_VALID;
                    end else if (w_expire) begin
                        r_fetch_error <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_wait_cnt    <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_VALID: begin
                    // A branch flushes the held word even if decode accepts it.
                    if (branch_taken || bus.instr_ready) begin
                        r_pc          <= w_pc_sel;
                        r_mem_addr    <= w_pc_sel;
                        r_mem_req     <= 1'b1;
                        r_instr_valid <= 1'b0;
                        r_wait_cnt    <= '0;
                        r_state       <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    instruction_fetch_register #(
        .WIDTH (DATAWIDTH)
    ) u_instr_reg (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_capture),
        .i_d    (bus.mem_rdata),
        .o_q    (w_instr)
    );

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.instr       = w_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;
    assign fetch_error     = r_fetch_error;
endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized branch/ack/ready traffic, compared cycle by cycle against a
// behavioural model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam int MAXW = 15;

    logic        clk;
    logic        reset;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        fetch_error;

    instruction_fetch_if #(.DATAWIDTH(16), .ADDRWIDTH(16)) bus ();

    instruction_fetch #(
        .DATAWIDTH    (16),
        .ADDRWIDTH    (16),
        .RESET_VECTOR (16'h0000),
        .MAX_WAIT     (MAXW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .fetch_error   (fetch_error),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = waiting one cycle after reset, 1 = fetching, 2 = holding for decode
    int          m_phase;
    logic [15:0] m_pc;
    logic        m_req;
    logic [15:0] m_addr;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    logic        m_valid;
    logic        m_err;
    int          m_unacked;

    task automatic model_reset();
        m_phase = 0; m_pc = 16'h0000; m_req = 1'b0; m_addr = 16'h0000;
        m_instr = 16'h0000; m_ipc = 16'h0000; m_valid = 1'b0; m_err = 1'b0;
        m_unacked = 0;
    endtask

    // Applies one clock edge worth of the fetch rules to the model.
    task automatic model_step(input logic bt, input logic [15:0] tgt, input logic ack,
                              input logic [15:0] rd, input logic rdy);
        m_err = 1'b0;
        if (m_phase == 0) begin
            if (bt) m_pc = tgt;
            m_addr = m_pc; m_req = 1'b1; m_unacked = 0; m_phase = 1;
        end else if (m_phase == 1) begin
            if (bt) begin
                m_pc = tgt; m_addr = tgt; m_req = 1'b1; m_unacked = 0;
            end else if (!m_req) begin
                m_req = 1'b1;
            end else if (ack) begin
                m_instr = rd; m_ipc = m_pc; m_pc = m_pc + 16'd1;
                m_req = 1'b0; m_valid = 1'b1; m_unacked = 0; m_phase = 2;
            end else begin
                m_unacked = m_unacked + 1;
                if (m_unacked == MAXW) begin
                    m_err = 1'b1; m_req = 1'b0; m_unacked = 0;
                end
            end
        end else begin
            if (bt || rdy) begin
                if (bt) m_pc = tgt;
                m_addr = m_pc; m_req = 1'b1; m_valid = 1'b0; m_unacked = 0; m_phase = 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("mem_req", 16'(bus.mem_req), 16'(m_req));
        if (m_req) chk("mem_addr", bus.mem_addr, m_addr);
        chk("instr_valid", 16'(bus.instr_valid), 16'(m_valid));
        if (m_valid) begin
            chk("instr", bus.instr, m_instr);
            chk("instr_pc", bus.instr_pc, m_ipc);
        end
        chk("fetch_error", 16'(fetch_error), 16'(m_err));
    endtask

    // One clock cycle: drive inputs, advance model, sample after the edge.
    task automatic cyc(input logic bt, input logic [15:0] tgt, input logic ack,
                       input logic [15:0] rd, input logic rdy);
        branch_taken    = bt;
        branch_target   = tgt;
        bus.mem_ack     = ack;
        bus.mem_rdata   = rd;
        bus.instr_ready = rdy;
        model_step(bt, tgt, ack, rd, rdy);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_mem_req"}, 16'(bus.mem_req), 16'h0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 16'h0000);
        chk({tag, "_instr"}, bus.instr, 16'h0000);
        chk({tag, "_instr_pc"}, bus.instr_pc, 16'h0000);
        chk({tag, "_instr_valid"}, 16'(bus.instr_valid), 16'h0);
        chk({tag, "_fetch_error"}, 16'(fetch_error), 16'h0);
    endtask

    // Asserts reset between clock edges and checks that it acts immediately.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] held;
        int          ack_pct;
        logic        bt;
        logic [15:0] tgt;

        clk = 1'b0; reset = 1'b0;
        branch_taken = 1'b0; branch_target = 16'h0000;
        bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0000; bus.instr_ready = 1'b0;
        model_reset();
        #3;
        check_reset_values("rst");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 1: two fetches, ack two cycles after each request
        cyc(0, 16'h0, 0, 16'h0, 1);
        chk("t1_addr0", bus.mem_addr, 16'h0000);
        chk("t1_req0", 16'(bus.mem_req), 16'h1);
        cyc(0, 16'h0, 0, 16'h0, 1);
        cyc(0, 16'h0, 1, 16'h1234, 1);
        chk("t1_instr0", bus.instr, 16'h1234);
        chk("t1_pc0", bus.instr_pc, 16'h0000);
        chk("t1_valid0", 16'(bus.instr_valid), 16'h1);
        cyc(0, 16'h0, 0, 16'h0, 1);
        chk("t1_addr1", bus.mem_addr, 16'h0001);
        cyc(0, 16'h0, 0, 16'h0, 1);
        cyc(0, 16'h0, 1, 16'h5678, 0);
        chk("t1_instr1", bus.instr, 16'h5678);
        chk("t1_pc1", bus.instr_pc, 16'h0001);

        // 2: decode stalls for five cycles
        for (int i = 0; i < 5; i++) begin
            cyc(0, 16'h0, 1, 16'hAAAA, 0);
            chk("t2_hold_instr", bus.instr, 16'h5678);
            chk("t2_hold_req", 16'(bus.mem_req), 16'h0);
        end
        cyc(0, 16'h0, 0, 16'h0, 1);
        chk("t2_next_addr", bus.mem_addr, 16'h0002);

        // 3: branch in REQ with a simultaneous ack
        cyc(1, 16'h00A0, 1, 16'hDEAD, 0);
        chk("t3_addr", bus.mem_addr, 16'h00A0);
        chk("t3_novalid", 16'(bus.instr_valid), 16'h0);
        cyc(0, 16'h0, 1, 16'hBEEF, 0);
        chk("t3_pc", bus.instr_pc, 16'h00A0);
        chk("t3_instr", bus.instr, 16'hBEEF);

        // 4: branch and ready together in VALID
        cyc(1, 16'h0200, 0, 16'h0, 1);
        chk("t4_flush", 16'(bus.instr_valid), 16'h0);
        chk("t4_addr", bus.mem_addr, 16'h0200);

        // 5: watchdog expiry, then an ack on the expiry cycle
        for (int i = 1; i < MAXW; i++) begin
            cyc(0, 16'h0, 0, 16'h0, 0);
            chk("t5_noerr", 16'(fetch_error), 16'h0);
        end
        cyc(0, 16'h0, 0, 16'h0, 0);
        chk("t5_err", 16'(fetch_error), 16'h1);
        chk("t5_req_drop", 16'(bus.mem_req), 16'h0);
        cyc(0, 16'h0, 0, 16'h0, 0);
        chk("t5_err_clear", 16'(fetch_error), 16'h0);
        chk("t5_rereq", 16'(bus.mem_req), 16'h1);
        chk("t5_readdr", bus.mem_addr, 16'h0200);
        for (int i = 1; i < MAXW; i++) cyc(0, 16'h0, 0, 16'h0, 0);
        cyc(0, 16'h0, 1, 16'h1111, 0);
        chk("t5_ack_wins_err", 16'(fetch_error), 16'h0);
        chk("t5_ack_wins_valid", 16'(bus.instr_valid), 16'h1);

        // 6: PC wrap and reset during REQ
        cyc(1, 16'hFFFF, 0, 16'h0, 0);
        chk("t6_addr_ffff", bus.mem_addr, 16'hFFFF);
        cyc(0, 16'h0, 1, 16'h4321, 0);
        chk("t6_pc_ffff", bus.instr_pc, 16'hFFFF);
        cyc(0, 16'h0, 0, 16'h0, 1);
        chk("t6_wrap_addr", bus.mem_addr, 16'h0000);
        chk("t6_req_before", 16'(bus.mem_req), 16'h1);
        async_reset("t6_rst");

        // randomized traffic, varying memory latency
        for (int seg = 0; seg < 6; seg++) begin
            ack_pct = (seg % 3 == 0) ? 5 : ((seg % 3 == 1) ? 30 : 80);
            for (int c = 0; c < 500; c++) begin
                bt  = ($urandom_range(0, 11) == 0);
                tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                cyc(bt, tgt, ($urandom_range(0, 99) < ack_pct), 16'($urandom),
                    ($urandom_range(0, 1) == 1));
            end
            async_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
